// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises a byte stream onto the LUT configuration chain
// and drives prog_clk, prog_rst and ccff_done. Optional readback: define CCFF_READBACK_EN.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN  = 18,
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       ccff_head,
    input  logic       ccff_tail,
    output logic       prog_clk,
    output logic       prog_rst,
    output logic       ccff_done,
    output logic       busy,
    output logic       load_done
`ifdef CCFF_READBACK_EN
    ,
    output logic [7:0] rb_data,
    output logic       rb_valid
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        FETCH,
        SLO,
        SHI,
        FIN
    } state_t;

    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic [3:0]       bits_in_byte;
    logic [3:0]       bits_nxt;
    logic [CNT_W-1:0] rst_cnt;
    logic [CNT_W-1:0] rst_cnt_nxt;

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        bits_nxt    = bits_in_byte;
        rst_cnt_nxt = rst_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = CRST;
                    bit_cnt_nxt = '0;
                    bits_nxt    = '0;
                    rst_cnt_nxt = '0;
                end
            end
            CRST: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt = FETCH;
                end else begin
                    rst_cnt_nxt = rst_cnt + CNT_W'(1);
                end
            end
            FETCH: begin
                if (cfg_valid && cfg_ready) begin
                    shreg_nxt = cfg_data;
                    bits_nxt  = 4'd8;
                    state_nxt = SLO;
                end
            end
            SLO: begin
                state_nxt = SHI;
            end
            SHI: begin
                shreg_nxt   = {shreg[6:0], 1'b0};
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
                bits_nxt    = bits_in_byte - 4'd1;
                // Chain length wins over byte exhaustion so a partial last byte ends the load.
                if (bit_cnt_nxt == CHAIN_LEN_C) begin
                    state_nxt = FIN;
                end else if (bits_nxt == 4'd0) begin
                    state_nxt = FETCH;
                end else begin
                    state_nxt = SLO;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            bits_in_byte <= '0;
            rst_cnt      <= '0;
            cfg_ready    <= 1'b0;
            ccff_head    <= 1'b0;
            prog_clk     <= 1'b0;
            prog_rst     <= 1'b0;
            ccff_done    <= 1'b0;
            busy         <= 1'b0;
            load_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            bit_cnt      <= bit_cnt_nxt;
            bits_in_byte <= bits_nxt;
            rst_cnt      <= rst_cnt_nxt;
            cfg_ready    <= (state_nxt == FETCH);
            prog_clk     <= (state_nxt == SHI);
            prog_rst     <= (state_nxt != CRST);
            ccff_done    <= (state_nxt == SLO) || (state_nxt == SHI);
            busy         <= (state_nxt != IDLE);
            load_done    <= (state_nxt == FIN);
            if (state_nxt == SLO) begin
                ccff_head <= shreg_nxt[7];
            end
        end
    end

`ifdef CCFF_READBACK_EN
    logic [6:0] rb_shreg;
    logic [3:0] rb_cnt;
    logic [7:0] rb_word;
    logic [3:0] rb_cnt_inc;
    logic       rb_last;

    always_comb begin
        rb_word    = {rb_shreg, ccff_tail};
        rb_cnt_inc = rb_cnt + 4'd1;
        rb_last    = (rb_cnt_inc == 4'd8) || ((bit_cnt + CNT_W'(1)) == CHAIN_LEN_C);
    end

    // ccff_tail is captured on the edge that raises prog_clk, before the chain shifts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rb_shreg <= '0;
            rb_cnt   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (state == IDLE && start) begin
                rb_shreg <= '0;
                rb_cnt   <= '0;
            end else if (state == SLO) begin
                if (rb_last) begin
                    rb_data  <= rb_word << (4'd8 - rb_cnt_inc);
                    rb_valid <= 1'b1;
                    rb_shreg <= '0;
                    rb_cnt   <= '0;
                end else begin
                    rb_shreg <= rb_word[6:0];
                    rb_cnt   <= rb_cnt_inc;
                end
            end
        end
    end
`else
    logic tail_unused;
    assign tail_unused = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two instances (CHAIN_LEN 18 and 16) driving
// behavioural chain models, checked against a bit-level reference of each load.
module tb_ccff_bitstream_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start     [2];
    logic [7:0] cfg_data  [2];
    logic       cfg_valid [2];
    logic       cfg_ready [2];
    logic       ccff_head [2];
    logic       ccff_tail [2];
    logic       prog_clk  [2];
    logic       prog_rst  [2];
    logic       ccff_done [2];
    logic       busy      [2];
    logic       load_done [2];
`ifdef CCFF_READBACK_EN
    logic [7:0] rb_data   [2];
    logic       rb_valid  [2];
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ccff_bitstream_loader #(
            .CHAIN_LEN (g == 0 ? 18 : 16),
            .RST_CYCLES(4),
            .CNT_W     (16)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start[g]),
            .cfg_data (cfg_data[g]),
            .cfg_valid(cfg_valid[g]),
            .cfg_ready(cfg_ready[g]),
            .ccff_head(ccff_head[g]),
            .ccff_tail(ccff_tail[g]),
            .prog_clk (prog_clk[g]),
            .prog_rst (prog_rst[g]),
            .ccff_done(ccff_done[g]),
            .busy     (busy[g]),
            .load_done(load_done[g])
`ifdef CCFF_READBACK_EN
            ,
            .rb_data  (rb_data[g]),
            .rb_valid (rb_valid[g])
`endif
        );
    end

    // Tile chains: bit 0 is next to ccff_head, the top bit feeds ccff_tail.
    logic [17:0] chain0 = '0;
    logic [15:0] chain1 = '0;
    always @(posedge prog_clk[0]) if (ccff_done[0]) chain0 <= {chain0[16:0], ccff_head[0]};
    always @(posedge prog_clk[1]) if (ccff_done[1]) chain1 <= {chain1[14:0], ccff_head[1]};
    assign ccff_tail[0] = chain0[17];
    assign ccff_tail[1] = chain1[15];

    int         cyc          = 0;
    int         edges    [2] = '{0, 0};
    int         accepts  [2] = '{0, 0};
    int         stalls   [2] = '{0, 0};
    int         prst_low [2] = '{0, 0};
    int         dones    [2] = '{0, 0};
    int         rdy_cyc  [2] = '{0, 0};
    int         rb_cnt   [2] = '{0, 0};
    int         last_rise[2] = '{0, 0};
    int         done_cyc [2] = '{0, 0};
    logic       pclk_prev[2] = '{1'b0, 1'b0};
    logic       head_mem [2][1024];
    logic [7:0] acc_mem  [2][256];
    logic [7:0] rb_mem   [2][256];

    // Observers run on the falling edge, half a cycle away from every DUT update.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            pclk_prev[i] <= prog_clk[i];
            if (prog_clk[i] && !pclk_prev[i]) begin
                head_mem[i][10'(edges[i] % 1024)] <= ccff_head[i];
                edges[i]     <= edges[i] + 1;
                last_rise[i] <= cyc;
            end
            if (cfg_valid[i] && cfg_ready[i]) begin
                acc_mem[i][8'(accepts[i] % 256)] <= cfg_data[i];
                accepts[i] <= accepts[i] + 1;
            end
            if (cfg_ready[i]) rdy_cyc[i] <= rdy_cyc[i] + 1;
            if (cfg_ready[i] && (prog_clk[i] || ccff_done[i])) stalls[i] <= stalls[i] + 1;
            if (busy[i] && !prog_rst[i]) prst_low[i] <= prst_low[i] + 1;
            if (load_done[i]) begin
                dones[i]    <= dones[i] + 1;
                done_cyc[i] <= cyc;
            end
`ifdef CCFF_READBACK_EN
            if (rb_valid[i]) begin
                rb_mem[i][8'(rb_cnt[i] % 256)] <= rb_data[i];
                rb_cnt[i] <= rb_cnt[i] + 1;
            end
`endif
        end
    end

    // Reference: chain contents per instance, left-aligned, first-shifted bit at bit 23.
    logic [23:0] prev_bits[2] = '{24'h0, 24'h0};
    bit          rb_known [2] = '{1'b1, 1'b1};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] outs(input int i);
        return {cfg_ready[i], ccff_head[i], prog_clk[i], prog_rst[i], ccff_done[i], busy[i], load_done[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitAccept(input int idx, output bit got);
        got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            got = cfg_ready[idx];
            tick();
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [23:0] stream, input int gap_min,
                                 input int gap_max, input bit glitch, output bit ok);
        int nb;
        int gap;
        bit got;
        bit seen;
        nb = (idx == 0) ? 3 : 2;
        ok = 1'b1;
        start[idx] = 1'b1;
        tick();
        start[idx] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            gap = int'($urandom_range(gap_max, gap_min));
            cfg_valid[idx] = 1'b0;
            repeat (gap) tick();
            cfg_data[idx]  = stream[23 - 8 * b -: 8];
            cfg_valid[idx] = 1'b1;
            waitAccept(idx, got);
            if (!got) ok = 1'b0;
            if (glitch && b == 0) begin
                start[idx] = 1'b1;
                tick();
                start[idx] = 1'b0;
            end
        end
        // Keep offering a byte that must never be taken.
        cfg_data[idx]  = 8'hEE;
        cfg_valid[idx] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            seen = load_done[idx];
        end
        if (!seen) ok = 1'b0;
        tick();
        cfg_valid[idx] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic runLoad(input int idx, input logic [23:0] stream, input int gap_min,
                           input int gap_max, input bit glitch);
        int          len;
        int          nb;
        int          e0, a0, s0, p0, d0, r0, b0;
        bit          ok;
        logic [23:0] exp_bits;
        logic [23:0] obs_bits;
        logic [23:0] exp_acc;
        logic [23:0] obs_acc;
        len = (idx == 0) ? 18 : 16;
        nb  = (len + 7) / 8;
        e0 = edges[idx];   a0 = accepts[idx]; s0 = stalls[idx];
        p0 = prst_low[idx]; d0 = dones[idx];  r0 = rdy_cyc[idx];
        b0 = rb_cnt[idx];
        applyStimulus(idx, stream, gap_min, gap_max, glitch, ok);
        exp_bits = stream & (24'hFFFFFF << (24 - len));
        exp_acc  = stream & (24'hFFFFFF << (24 - 8 * nb));
        obs_bits = '0;
        for (int k = 0; k < len; k++) obs_bits[23 - k] = head_mem[idx][10'((e0 + k) % 1024)];
        obs_acc = '0;
        for (int k = 0; k < nb; k++) obs_acc[23 - 8 * k -: 8] = acc_mem[idx][8'((a0 + k) % 256)];
        checkOutput("handshake", 32'(ok), 32'd1);
        checkOutput("edges", edges[idx] - e0, len);
        checkOutput("head_bits", 32'(obs_bits), 32'(exp_bits));
        checkOutput("accepts", accepts[idx] - a0, nb);
        checkOutput("accepted_bytes", 32'(obs_acc), 32'(exp_acc));
        checkOutput("prst_low_cycles", prst_low[idx] - p0, 4);
        checkOutput("done_pulses", dones[idx] - d0, 1);
        checkOutput("done_after_last_edge", done_cyc[idx] - last_rise[idx], 1);
        checkOutput("fetch_stall_quiet", stalls[idx] - s0, 0);
        if (gap_max == 0) checkOutput("ready_cycles", rdy_cyc[idx] - r0, nb);
        checkOutput("busy_end", 32'(busy[idx]), 32'd0);
`ifdef CCFF_READBACK_EN
        checkOutput("rb_pulses", rb_cnt[idx] - b0, nb);
        if (rb_known[idx]) begin
            obs_acc = '0;
            for (int k = 0; k < nb; k++) obs_acc[23 - 8 * k -: 8] = rb_mem[idx][8'((b0 + k) % 256)];
            checkOutput("rb_data", 32'(obs_acc), 32'(prev_bits[idx]));
        end
`endif
        prev_bits[idx] = exp_bits;
        rb_known[idx]  = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          got;
        int          idx;
        logic [23:0] stream;
        for (int i = 0; i < 2; i++) begin
            start[i]     = 1'b0;
            cfg_data[i]  = 8'h00;
            cfg_valid[i] = 1'b0;
        end
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset_outs0", 32'(outs(0)), 32'h0);
        checkOutput("reset_outs1", 32'(outs(1)), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("idle_outs0", 32'(outs(0)), 32'h08);
        checkOutput("idle_outs1", 32'(outs(1)), 32'h08);
        tick();

        runLoad(0, 24'hA53CC0, 0, 0, 1'b0);
        runLoad(0, 24'hA53CC0, 5, 5, 1'b0);
        runLoad(0, 24'($urandom), 0, 0, 1'b1);

        // Abort in the middle of the second byte.
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        cfg_data[0]  = 8'h5A;
        cfg_valid[0] = 1'b1;
        waitAccept(0, got);
        cfg_data[0] = 8'hC3;
        waitAccept(0, got);
        checkOutput("abort_accept", 32'(got), 32'd1);
        cfg_valid[0] = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy[0]), 32'd1);
        tick();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_outs", 32'(outs(0)), 32'h0);
        tick();
        rst = 1'b1;
        rb_known[0] = 1'b0;
        repeat (2) tick();
        runLoad(0, 24'($urandom), 0, 0, 1'b0);

        runLoad(1, 24'hA53C00, 0, 0, 1'b0);

        runLoad(0, 24'hFFFFFF, 0, 0, 1'b0);
        runLoad(0, 24'h000000, 0, 0, 1'b0);
        runLoad(0, 24'h000000, 0, 0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            idx    = int'($urandom_range(1, 0));
            stream = 24'($urandom);
            runLoad(idx, stream, 0, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
